// File: rtl/dist_ram_fifo_ctrl.sv
// First-word-fall-through byte FIFO controller for an external 16x8 distributed RAM
// with asynchronous read; the registered output stage holds one byte beyond the RAM depth.
module dist_ram_fifo_ctrl #(
    parameter int unsigned AFULL_THR = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic [4:0] level,
    output logic       almost_full,
    output logic       overflow,
    output logic [7:0] ram_wdata,
    output logic       ram_we,
    output logic [3:0] ram_waddr,
    output logic [3:0] ram_raddr,
    input  logic [7:0] ram_rdata
);

    localparam logic [4:0] RAM_DEPTH = 5'd16;

    logic [3:0] wr_ptr;
    logic [3:0] rd_ptr;
    logic [4:0] ram_cnt;
    logic       ram_full;
    logic       ram_empty;
    logic       ld;
    logic       pop_only;

    assign ram_full  = (ram_cnt == RAM_DEPTH);
    assign ram_empty = (ram_cnt == 5'd0);

    assign wr_ready  = ~ram_full & ~flush;
    assign ram_we    = wr_valid & wr_ready;
    assign ram_wdata = wr_data;
    assign ram_waddr = wr_ptr;
    assign ram_raddr = rd_ptr;

    // A byte written this cycle is not bypassed into the output register; it
    // becomes visible only once it sits in the RAM, giving the two-cycle latency.
    assign ld       = ~ram_empty & (~rd_valid | rd_ready) & ~flush;
    assign pop_only = rd_valid & rd_ready & ~ld;

    assign level       = ram_cnt + {4'b0000, rd_valid};
    assign almost_full = (level >= 5'(AFULL_THR));

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values of ram_cnt, rd_valid and the pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= 8'h00;
            overflow <= 1'b0;
        end else if (flush) begin
            // rd_data deliberately holds; rd_valid=0 marks it stale.
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (ram_we) begin
                wr_ptr <= wr_ptr + 4'd1;
            end

            if (ld) begin
                rd_data  <= ram_rdata;
                rd_valid <= 1'b1;
                rd_ptr   <= rd_ptr + 4'd1;
            end else if (pop_only) begin
                rd_valid <= 1'b0;
            end

            case ({ram_we, ld})
                2'b10:   ram_cnt <= ram_cnt + 5'd1;
                2'b01:   ram_cnt <= ram_cnt - 5'd1;
                default: ram_cnt <= ram_cnt;
            endcase

            if (wr_valid && !wr_ready) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dist_ram_fifo_ctrl.sv
// Bench for dist_ram_fifo_ctrl: directed scenarios plus random traffic against a
// queue-based model of the RAM contents and the output register.
module tb_dist_ram_fifo_ctrl;

    localparam int unsigned AFULL = 12;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [4:0] level;
    logic       almost_full;
    logic       overflow;
    logic [7:0] ram_wdata;
    logic       ram_we;
    logic [3:0] ram_waddr;
    logic [3:0] ram_raddr;
    logic [7:0] ram_rdata;

    logic [7:0] mem [16];

    int checks   = 0;
    int failures = 0;

    // Reference model: bytes held in the RAM in arrival order, plus the output register.
    logic [7:0] m_ram_q [$];
    logic       m_out_v;
    logic [7:0] m_out_d;
    logic       m_ovf;
    logic [3:0] m_wptr;
    logic [3:0] m_rptr;

    always #5 clk = ~clk;

    dist_ram_fifo_ctrl #(.AFULL_THR(AFULL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .level       (level),
        .almost_full (almost_full),
        .overflow    (overflow),
        .ram_wdata   (ram_wdata),
        .ram_we      (ram_we),
        .ram_waddr   (ram_waddr),
        .ram_raddr   (ram_raddr),
        .ram_rdata   (ram_rdata)
    );

    // Distributed RAM: synchronous write, asynchronous read, never cleared by reset.
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
    end
    assign ram_rdata = mem[ram_raddr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input bit clear_data);
        m_ram_q.delete();
        m_out_v = 1'b0;
        m_ovf   = 1'b0;
        m_wptr  = 4'd0;
        m_rptr  = 4'd0;
        if (clear_data) m_out_d = 8'h00;
    endtask

    function automatic int m_level();
        return m_ram_q.size() + int'(m_out_v);
    endfunction

    task automatic compare_all();
        bit exp_wr_ready;
        exp_wr_ready = (m_ram_q.size() != 16) && !flush;
        check("wr_ready",    wr_ready,    exp_wr_ready);
        check("ram_we",      ram_we,      wr_valid && exp_wr_ready);
        check("ram_wdata",   ram_wdata,   wr_data);
        check("ram_waddr",   ram_waddr,   m_wptr);
        check("ram_raddr",   ram_raddr,   m_rptr);
        check("rd_valid",    rd_valid,    m_out_v);
        check("rd_data",     rd_data,     m_out_d);
        check("level",       level,       m_level());
        check("almost_full", almost_full, m_level() >= int'(AFULL));
        check("overflow",    overflow,    m_ovf);
    endtask

    task automatic model_step();
        bit acc, ldm;
        acc = wr_valid && (m_ram_q.size() != 16) && !flush;
        ldm = (m_ram_q.size() != 0) && (!m_out_v || rd_ready) && !flush;
        if (flush) begin
            model_reset(1'b0);
        end else begin
            if (wr_valid && !acc) m_ovf = 1'b1;
            if (ldm) begin
                m_out_d = m_ram_q.pop_front();
                m_out_v = 1'b1;
                m_rptr  = m_rptr + 4'd1;
            end else if (m_out_v && rd_ready) begin
                m_out_v = 1'b0;
            end
            if (acc) begin
                m_ram_q.push_back(wr_data);
                m_wptr = m_wptr + 4'd1;
            end
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic cycle(input logic wv, input logic [7:0] wd, input logic rr, input logic fl);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        flush    = fl;
        #1;
        compare_all();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fill17();
        for (int i = 0; i < 17; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    endtask

    initial begin
        int max_lvl;
        foreach (mem[i]) mem[i] = 8'hEE;
        rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0;
        model_reset(1'b1);
        repeat (2) @(negedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single byte, two-edge latency
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        check("t1_not_yet", rd_valid, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("t1_valid", rd_valid, 1'b1);
        check("t1_data",  rd_data,  8'hA5);
        check("t1_level", level,    5'd1);

        // 2: fill to 17, then one refused write sets overflow
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        fill17();
        check("t2_level",    level,       5'd17);
        check("t2_afull",    almost_full, 1'b1);
        check("t2_wr_ready", wr_ready,    1'b0);
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        check("t2_overflow", overflow, 1'b1);

        // 3: drain from full, in order, one byte per cycle
        for (int i = 0; i < 17; i++) begin
            check("t3_byte", rd_data, 32'(i));
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            if (i == 0) check("t3_wr_ready", wr_ready, 1'b1);
        end
        check("t3_level", level, 5'd0);

        // 4: 40-byte stream with both sides always ready
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        max_lvl = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
            if (int'(level) > max_lvl) max_lvl = int'(level);
        end
        repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("t4_max_level", max_lvl <= 2, 1'b1);
        check("t4_overflow",  overflow,     1'b0);
        check("t4_wptr_wrap", ram_waddr,    4'd8);

        // 5: flush at level 9 with overflow set and a write attempted
        fill17();
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        repeat (8) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("t5_level_pre", level,    5'd9);
        check("t5_ovf_pre",   overflow, 1'b1);
        cycle(1'b1, 8'hFF, 1'b0, 1'b1);
        check("t5_level",    level,    5'd0);
        check("t5_rd_valid", rd_valid, 1'b0);
        check("t5_overflow", overflow, 1'b0);
        repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("t5_not_stored", rd_valid, 1'b0);

        // 6: asynchronous reset at level 5, between clock edges
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
        check("t6_level_pre", level, 5'd5);
        wr_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset(1'b1);
        check("t6_level",    level,       5'd0);
        check("t6_rd_valid", rd_valid,    1'b0);
        check("t6_rd_data",  rd_data,     8'h00);
        check("t6_overflow", overflow,    1'b0);
        check("t6_afull",    almost_full, 1'b0);
        check("t6_wr_ready", wr_ready,    1'b1);
        check("t6_ram_we",   ram_we,      1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 5 && !rd_valid; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("t6_first_valid", rd_valid, 1'b1);
        check("t6_first_data",  rd_data,  8'h3C);

        // Random traffic with occasional flushes
        for (int i = 0; i < 500; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 40) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
